// File: rtl/systolic_pkg.sv
// Shared definitions for the 16x16 systolic MMA datapath: the operand feeder,
// the PE array and the downstream result drain all import this package.
//   N        tile dimension (the array is N x N)
//   DATA_W   operand width presented to each PE a_in/b_in
//   IDX_W    width of a tile row index
//   feeder_state_t  operand feeder control states
package systolic_pkg;

  localparam int N      = 16;
  localparam int DATA_W = 8;
  localparam int IDX_W  = $clog2(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_t;

endpackage : systolic_pkg

// File: rtl/skew_lane_sel.sv
// One skew lane of the operand feeder. Lane k runs k beats behind lane 0, so
// at beat t it presents element (t - k) of its length-N operand vector. Before
// the lane's window opens, and after it closes, it presents zero.
//   lane  in   lane number k
//   t     in   beat number being prepared
//   vec   in   N operands, element c at bits [c*DATA_W +: DATA_W]
//   elem  out  element t-k, or 0 outside 0 <= t-k < N
module skew_lane_sel #(
  parameter int N      = 16,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic [IDX_W-1:0]    lane,
  input  logic [IDX_W:0]      t,
  input  logic [N*DATA_W-1:0] vec,
  output logic [DATA_W-1:0]   elem
);

  localparam logic [IDX_W:0] N_LEN = (IDX_W+1)'(N);

  logic [IDX_W:0]   offset;
  logic [IDX_W-1:0] idx;
  logic             in_window;

  assign offset    = t - {1'b0, lane};
  // The subtraction may underflow; the explicit t >= lane term rejects that case.
  assign in_window = (t >= {1'b0, lane}) && (offset < N_LEN);
  assign idx       = offset[IDX_W-1:0];

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    elem = '0;
    if (in_window) begin
      elem = vec[idx*DATA_W +: DATA_W];
    end
  end

endmodule : skew_lane_sel

// File: rtl/systolic_skew_feeder.sv
// Upstream stage of the systolic MMA array. Holds one A tile (row-major) and
// one B tile, then streams them into the array edges with a diagonal skew:
// row i of A feeds array row i on the left edge, column j of B feeds array
// column j on the top edge, and lane k is delayed by k beats so that matching
// operands meet inside the PEs. A stream is 2N-1 beats long.
//   clk, rst   clock and synchronous active-high reset
//   in_valid   write one tile row (accepted when in_ready is high)
//   in_ready   high only while idle
//   in_sel     0 = A row, 1 = B row
//   in_idx     row index
//   in_row     row data, element c at bits [c*DATA_W +: DATA_W]
//   start      begin streaming the buffered tiles (idle only)
//   busy       high while streaming and during the done cycle
//   out_valid  a_edge/b_edge hold a valid beat
//   a_edge     lane i -> array row i a_in
//   b_edge     lane j -> array column j b_in
//   done       one-cycle pulse after the last beat
module systolic_skew_feeder #(
  parameter int N      = systolic_pkg::N,
  parameter int DATA_W = systolic_pkg::DATA_W,
  parameter int IDX_W  = systolic_pkg::IDX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sel,
  input  logic [IDX_W-1:0]    in_idx,
  input  logic [N*DATA_W-1:0] in_row,
  input  logic                start,
  output logic                busy,
  output logic                out_valid,
  output logic [N*DATA_W-1:0] a_edge,
  output logic [N*DATA_W-1:0] b_edge,
  output logic                done
);

  import systolic_pkg::*;

  localparam int             ROW_W     = N * DATA_W;
  localparam logic [IDX_W:0] LAST_BEAT = (IDX_W+1)'(2*N-2);
  localparam logic [IDX_W:0] N_ROWS    = (IDX_W+1)'(N);

  feeder_state_t    state;
  logic [IDX_W:0]   t;          // beat currently on the edges
  logic [IDX_W:0]   beat_nxt;   // beat being loaded into the edge registers
  logic             stream_nxt; // edge registers load a valid beat this edge
  logic             wr_en;

  logic [ROW_W-1:0] a_buf [N];
  logic [ROW_W-1:0] b_buf [N];
  logic [ROW_W-1:0] a_nxt [N];  // buffers with this cycle's write applied
  logic [ROW_W-1:0] b_nxt [N];
  logic [ROW_W-1:0] b_col [N];  // b_nxt transposed: column j as a vector
  logic [ROW_W-1:0] a_sel;
  logic [ROW_W-1:0] b_sel;

  // Rows beyond N (only possible for non power-of-two N) are handshaken but dropped.
  assign wr_en = in_valid && in_ready && ({1'b0, in_idx} < N_ROWS);

  // Beat 0 is loaded on the same edge as the start, so it must already see a
  // row written on that edge; the lane selectors therefore read the buffers
  // with the pending write merged in.
  always_comb begin
    a_nxt = a_buf;
    b_nxt = b_buf;
    if (wr_en) begin
      if (in_sel) b_nxt[in_idx] = in_row;
      else        a_nxt[in_idx] = in_row;
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      b_col[j] = '0;
      for (int r = 0; r < N; r++) begin
        b_col[j][r*DATA_W +: DATA_W] = b_nxt[r][j*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: these tile buffers are plain flops, not a RAM macro, so they can and
  // must be cleared by reset along with the rest of the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        a_buf[r] <= '0;
        b_buf[r] <= '0;
      end
    end else begin
      a_buf <= a_nxt;
      b_buf <= b_nxt;
    end
  end

  always_comb begin
    beat_nxt   = '0;
    stream_nxt = 1'b0;
    case (state)
      IDLE: begin
        beat_nxt   = '0;
        stream_nxt = start;
      end
      STREAM: begin
        beat_nxt   = t + 1'b1;
        stream_nxt = (t != LAST_BEAT);
      end
      default: begin
        beat_nxt   = '0;
        stream_nxt = 1'b0;
      end
    endcase
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_lane_sel #(
      .N      (N),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
    ) u_a_lane (
      .lane (IDX_W'(g)),
      .t    (beat_nxt),
      .vec  (a_nxt[g]),
      .elem (a_sel[g*DATA_W +: DATA_W])
    );

    skew_lane_sel #(
      .N      (N),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
    ) u_b_lane (
      .lane (IDX_W'(g)),
      .t    (beat_nxt),
      .vec  (b_col[g]),
      .elem (b_sel[g*DATA_W +: DATA_W])
    );
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      t         <= '0;
      a_edge    <= '0;
      b_edge    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      // Edges default to zero; only a valid beat overrides them.
      a_edge    <= '0;
      b_edge    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (stream_nxt) begin
        a_edge    <= a_sel;
        b_edge    <= b_sel;
        out_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= STREAM;
            t        <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        STREAM: begin
          if (t == LAST_BEAT) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            t <= t + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule : systolic_skew_feeder

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder. The reference model keeps the two tiles as
// plain matrices and derives each expected beat from the skew rule
// (lane i carries A[i][t-i], lane j carries B[t-j][j]). A second model plays
// the captured edges through an idealised output-stationary array and compares
// every accumulated product with a direct matrix multiply.
module tb_systolic_skew_feeder;

  import systolic_pkg::*;

  localparam int ROW_W = N * DATA_W;
  localparam int BEATS = 2*N - 1;

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_sel   = 1'b0;
  logic [IDX_W-1:0] in_idx   = '0;
  logic [ROW_W-1:0] in_row   = '0;
  logic             start    = 1'b0;
  logic             in_ready;
  logic             busy;
  logic             out_valid;
  logic             done;
  logic [ROW_W-1:0] a_edge;
  logic [ROW_W-1:0] b_edge;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] ref_a [N][N];
  logic [DATA_W-1:0] ref_b [N][N];
  logic [ROW_W-1:0]  cap_a [BEATS];
  logic [ROW_W-1:0]  cap_b [BEATS];

  always #5 clk = ~clk;

  systolic_skew_feeder #(
    .N      (N),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_idx    (in_idx),
    .in_row    (in_row),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .a_edge    (a_edge),
    .b_edge    (b_edge),
    .done      (done)
  );

  // ---------------- reference model ----------------
  function automatic logic [ROW_W-1:0] exp_a_vec(input int t);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (t - i >= 0 && t - i < N) v[i*DATA_W +: DATA_W] = ref_a[i][t-i];
    end
    return v;
  endfunction

  function automatic logic [ROW_W-1:0] exp_b_vec(input int t);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) begin
      if (t - j >= 0 && t - j < N) v[j*DATA_W +: DATA_W] = ref_b[t-j][j];
    end
    return v;
  endfunction

  function automatic logic [ROW_W-1:0] pack_row(input bit sel, input int r);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) begin
      v[c*DATA_W +: DATA_W] = sel ? ref_b[r][c] : ref_a[r][c];
    end
    return v;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ref_a[r][c] = '0;
        ref_b[r][c] = '0;
      end
  endtask

  // ---------------- stimulus helpers (entered and left just after a negedge) ----
  task automatic write_row(input bit sel, input int r);
    in_valid = 1'b1;
    in_sel   = sel;
    in_idx   = r[IDX_W-1:0];
    in_row   = pack_row(sel, r);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_tiles();
    for (int r = 0; r < N; r++) begin
      write_row(1'b0, r);
      write_row(1'b1, r);
    end
  endtask

  // Starts a stream, captures every beat and checks data, handshake and the
  // done pulse against the model. With inject set, a write and a start are
  // presented mid-stream; both must be ignored.
  task automatic run_stream(input string name, input bit inject);
    int valid_cnt;
    int bad_ctl;
    valid_cnt = 0;
    bad_ctl   = 0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      cap_a[b] = a_edge;
      cap_b[b] = b_edge;
      if (out_valid) valid_cnt++;
      if (!busy || in_ready || done) bad_ctl++;
      if (inject && b == 8) begin
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_idx   = '0;
        in_row   = {N{8'hA5}};
        start    = 1'b1;
      end else if (inject && b == 9) begin
        in_valid = 1'b0;
        start    = 1'b0;
      end
      @(negedge clk);
    end

    n_cmp++;
    if (valid_cnt !== BEATS) begin
      n_err++;
      $display("FAIL %s valid_beats: got %0d want %0d", name, valid_cnt, BEATS);
    end
    n_cmp++;
    if (bad_ctl !== 0) begin
      n_err++;
      $display("FAIL %s busy_ready_during_stream: %0d bad beats, want 0", name, bad_ctl);
    end
    for (int b = 0; b < BEATS; b++) begin
      n_cmp++;
      if (cap_a[b] !== exp_a_vec(b)) begin
        n_err++;
        $display("FAIL %s a_edge beat %0d: got %h want %h", name, b, cap_a[b], exp_a_vec(b));
      end
      n_cmp++;
      if (cap_b[b] !== exp_b_vec(b)) begin
        n_err++;
        $display("FAIL %s b_edge beat %0d: got %h want %h", name, b, cap_b[b], exp_b_vec(b));
      end
    end

    // Cycle k+2N: done pulse, edges cleared, still busy.
    n_cmp++;
    if ({done, out_valid, busy, |{a_edge, b_edge}} !== 4'b1010) begin
      n_err++;
      $display("FAIL %s done_cycle {done,valid,busy,edge_nz}: got %b want 1010", name,
               {done, out_valid, busy, |{a_edge, b_edge}});
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy, in_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL %s back_to_idle {done,busy,ready}: got %b want 001", name,
               {done, busy, in_ready});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({a_edge, b_edge} !== '0) begin
      n_err++;
      $display("FAIL reset_edges: got %h want 0", {a_edge, b_edge});
    end
    n_cmp++;
    if ({out_valid, done, busy, in_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_flags {valid,done,busy,ready}: got %b want 0001",
               {out_valid, done, busy, in_ready});
    end
    clear_model();
    run_stream("zero_stream", 1'b0);
  endtask

  task automatic test_identity();
    clear_model();
    for (int i = 0; i < N; i++) begin
      ref_a[i][i] = 8'd1;
      ref_b[i][i] = 8'd1;
    end
    load_tiles();
    run_stream("identity", 1'b0);
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (cap_a[2*i][i*DATA_W +: DATA_W] !== 8'd1) begin
        n_err++;
        $display("FAIL identity_diag lane %0d: got %0d want 1", i, cap_a[2*i][i*DATA_W +: DATA_W]);
      end
    end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < N; i++)
      for (int c = 0; c < N; c++) begin
        ref_a[i][c] = DATA_W'(16*i + c);
        ref_b[i][c] = DATA_W'($urandom_range(0, 255));
      end
    load_tiles();
    run_stream("ramp", 1'b0);
    n_cmp++;
    if (cap_a[5][0 +: DATA_W] !== 8'd5) begin
      n_err++;
      $display("FAIL ramp_t5_lane0: got %0d want 5", cap_a[5][0 +: DATA_W]);
    end
    n_cmp++;
    if (cap_a[5][3*DATA_W +: DATA_W] !== 8'd50) begin
      n_err++;
      $display("FAIL ramp_t5_lane3: got %0d want 50", cap_a[5][3*DATA_W +: DATA_W]);
    end
    n_cmp++;
    if (cap_a[30] !== {8'd255, {(ROW_W-DATA_W){1'b0}}}) begin
      n_err++;
      $display("FAIL ramp_t30: got %h want only lane 15 = ff", cap_a[30]);
    end
  endtask

  task automatic test_random_matmul();
    int acc;
    int want;
    for (int i = 0; i < N; i++)
      for (int c = 0; c < N; c++) begin
        ref_a[i][c] = DATA_W'($urandom);
        ref_b[i][c] = DATA_W'($urandom);
      end
    load_tiles();
    run_stream("random", 1'b0);
    // PE(i,j) sees row-lane i delayed j hops and column-lane j delayed i hops.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc  = 0;
        want = 0;
        for (int s = 0; s < 2*BEATS; s++) begin
          if (s - j >= 0 && s - j < BEATS && s - i >= 0 && s - i < BEATS)
            acc += int'(cap_a[s-j][i*DATA_W +: DATA_W]) * int'(cap_b[s-i][j*DATA_W +: DATA_W]);
        end
        for (int k = 0; k < N; k++) want += int'(ref_a[i][k]) * int'(ref_b[k][j]);
        n_cmp++;
        if (acc !== want) begin
          n_err++;
          $display("FAIL matmul C[%0d][%0d]: got %0d want %0d", i, j, acc, want);
        end
      end
  endtask

  task automatic test_busy_protect();
    run_stream("busy_inject", 1'b1);
    run_stream("replay", 1'b0);
  endtask

  task automatic test_same_edge_write();
    for (int c = 0; c < N; c++) ref_a[0][c] = 8'd7;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_idx   = '0;
    in_row   = pack_row(1'b0, 0);
    run_stream("same_edge", 1'b0);
    n_cmp++;
    if (cap_a[0][0 +: DATA_W] !== 8'd7) begin
      n_err++;
      $display("FAIL same_edge_beat0_lane0: got %0d want 7", cap_a[0][0 +: DATA_W]);
    end
  endtask

  task automatic test_reset_mid_stream();
    int seen_done;
    seen_done = 0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 10; b++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    // Now at beat 10.
    n_cmp++;
    if (a_edge !== exp_a_vec(10)) begin
      n_err++;
      $display("FAIL midreset_beat10: got %h want %h", a_edge, exp_a_vec(10));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({a_edge, b_edge} !== '0 || {out_valid, done, busy, in_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL midreset_after {valid,done,busy,ready}: got %b want 0001, edges %h",
               {out_valid, done, busy, in_ready}, {a_edge, b_edge});
    end
    for (int c = 0; c < 2*N; c++) begin
      if (done || out_valid) seen_done++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen_done !== 0) begin
      n_err++;
      $display("FAIL midreset_no_done: %0d cycles with done/valid, want 0", seen_done);
    end
    clear_model();
    run_stream("post_reset_zero", 1'b0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_ramp();
    test_random_matmul();
    test_busy_protect();
    test_same_edge_write();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_systolic_skew_feeder
